// File: rtl/regfile_writeback.sv
// Register-file write-side master: arbitrates ALU results against buffered load returns
// onto the single write port and tracks destinations of outstanding loads for hazards.
module regfile_writeback #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic [4:0]      rf_addr_rd,
    output logic [XLEN-1:0] rf_data_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            hazard
);

    localparam int unsigned AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

    logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
    logic [4:0]      lq_rd_q   [LQ_DEPTH];
    logic [AW:0]     wptr_q, rptr_q;
    logic [31:0]     pending_q, pending_d;
    logic            rf_we_q;
    logic [4:0]      rf_addr_q;
    logic [XLEN-1:0] rf_data_q;

    logic            full, empty, push, pop, alu_win;
    logic [4:0]      head_rd, win_rd;
    logic [XLEN-1:0] head_data, win_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign ld_ready  = !full;
    assign alu_ready = !full;
    assign push      = ld_valid && !full;
    assign alu_win   = alu_valid && !full;
    // A full queue always drains first; otherwise loads only use idle ALU slots.
    assign pop       = full || (!alu_valid && !empty);

    assign head_rd   = lq_rd_q[rptr_q[AW-1:0]];
    assign head_data = lq_data_q[rptr_q[AW-1:0]];
    assign win_rd    = pop ? head_rd : alu_rd;
    assign win_data  = pop ? head_data : alu_data;

    assign hazard = pending_q[chk_rs1] | pending_q[chk_rs2];

    always_comb begin
        pending_d = pending_q;
        if (pop && (head_rd != 5'd0)) begin
            pending_d[head_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle reissue keeps the bit set.
        if (ld_issue && (ld_issue_rd != 5'd0)) begin
            pending_d[ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd_q[wptr_q[AW-1:0]]   <= ld_rd;
            lq_data_q[wptr_q[AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            pending_q <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (push) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
            if (alu_win || pop) begin
                rf_we_q   <= (win_rd != 5'd0);
                rf_addr_q <= win_rd;
                rf_data_q <= win_data;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_addr_rd = rf_addr_q;
    assign rf_data_rd = rf_data_q;

endmodule
